// File: rtl/systolic_cube_mc_if.sv
// Bus bundle for systolic_cube_mc: start/ready handshake, shared D/W read port
// and the result RAM write port.
interface systolic_cube_mc_if #(
   parameter int AW = 11
);
   logic          iStart;
   logic          oReady;
   logic [AW-1:0] oAddrForDataWeightRam;
   logic [31:0]   iDataFromDataRam;
   logic [31:0]   iWeightFromWeightRam;
   logic          oWrEnForResultRam;
   logic [AW-1:0] oAddrForResultRam;
   logic [31:0]   oDataToResultRam;

   modport slave (
      input  iStart, iDataFromDataRam, iWeightFromWeightRam,
      output oReady, oAddrForDataWeightRam, oWrEnForResultRam,
             oAddrForResultRam, oDataToResultRam
   );

   modport master (
      output iStart, iDataFromDataRam, iWeightFromWeightRam,
      input  oReady, oAddrForDataWeightRam, oWrEnForResultRam,
             oAddrForResultRam, oDataToResultRam
   );
endinterface

// File: rtl/systolic_cube_mc.sv
// Matrix-multiply engine R = D x W with its own load/compute/write sequencer.
// Optional macro SYSTOLIC_CUBE_RELU_EN clamps negative results to 0 at write time.
module systolic_cube_mc #(
   parameter int ARRAY_NUM = 3,
   parameter int BLOCK_NUM = 3,
   parameter int CUBE_NUM  = 3,
   parameter int RAM_DEPTH = 2048
) (
   input logic               iClk,
   input logic               iRst,
   systolic_cube_mc_if.slave bus
);
   localparam int AW   = $clog2(RAM_DEPTH);
   localparam int D_SZ = ARRAY_NUM * CUBE_NUM;
   localparam int W_SZ = CUBE_NUM * BLOCK_NUM;
   localparam int R_SZ = ARRAY_NUM * BLOCK_NUM;
   localparam int L    = (D_SZ > W_SZ) ? D_SZ : W_SZ;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_COMPUTE, S_WRITE} state_t;

   state_t               state, state_nxt;
   logic [AW-1:0]        cnt, cnt_nxt;
   logic                 vld_p1;
   logic [AW-1:0]        rd_addr_p1;
   logic [AW-1:0]        rd_addr;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic signed [31:0]   wr_data;
   logic signed [31:0]   wr_sel;
   logic signed [31:0]   d_rf    [ARRAY_NUM][CUBE_NUM];
   logic signed [31:0]   w_rf    [CUBE_NUM][BLOCK_NUM];
   logic signed [31:0]   acc     [ARRAY_NUM][BLOCK_NUM];
   logic signed [31:0]   acc_nxt [ARRAY_NUM][BLOCK_NUM];

   function automatic logic signed [31:0] post_proc(input logic signed [31:0] v);
`ifdef SYSTOLIC_CUBE_RELU_EN
      post_proc = v[31] ? 32'sd0 : v;
`else
      post_proc = v;
`endif
   endfunction

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // cnt is the LOAD address, the COMPUTE step k, or the WRITE index n
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (bus.iStart) begin
               state_nxt = S_LOAD;
               cnt_nxt   = '0;
            end
         end
         S_LOAD: begin
            if (cnt == AW'(L - 1)) begin
               state_nxt = S_WAIT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_WAIT: begin
            state_nxt = S_COMPUTE;
            cnt_nxt   = '0;
         end
         S_COMPUTE: begin
            if (cnt == AW'(CUBE_NUM - 1)) begin
               state_nxt = S_WRITE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_WRITE: begin
            if (cnt == AW'(R_SZ - 1)) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Stage p0 -> p1: the word for an address arrives one cycle after the RAM samples it
   always_ff @(posedge iClk) begin
      if (vld_p1) begin
         for (int i = 0; i < ARRAY_NUM; i++)
            for (int k = 0; k < CUBE_NUM; k++)
               if (rd_addr_p1 == AW'(i * CUBE_NUM + k)) d_rf[i][k] <= bus.iDataFromDataRam;
         for (int k = 0; k < CUBE_NUM; k++)
            for (int j = 0; j < BLOCK_NUM; j++)
               if (rd_addr_p1 == AW'(k * BLOCK_NUM + j)) w_rf[k][j] <= bus.iWeightFromWeightRam;
      end
   end

   // acc_nxt folds in the current step so the first write sees the final sum
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < ARRAY_NUM; i++) begin
         for (int j = 0; j < BLOCK_NUM; j++) begin
            acc_nxt[i][j] = acc[i][j];
            if (state == S_COMPUTE)
               for (int k = 0; k < CUBE_NUM; k++)
                  if (cnt == AW'(k)) acc_nxt[i][j] = acc[i][j] + d_rf[i][k] * w_rf[k][j];
            if (cnt_nxt == AW'(i * BLOCK_NUM + j)) wr_sel = acc_nxt[i][j];
         end
      end
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         for (int i = 0; i < ARRAY_NUM; i++)
            for (int j = 0; j < BLOCK_NUM; j++) acc[i][j] <= '0;
      end else if (state == S_IDLE && bus.iStart) begin
         for (int i = 0; i < ARRAY_NUM; i++)
            for (int j = 0; j < BLOCK_NUM; j++) acc[i][j] <= '0;
      end else begin
         acc <= acc_nxt;
      end
   end

   // Output registers follow the next state so each port changes on the state edge
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         rd_addr    <= '0;
         vld_p1     <= 1'b0;
         rd_addr_p1 <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         rd_addr    <= (state_nxt == S_LOAD) ? cnt_nxt : '0;
         vld_p1     <= (state == S_LOAD);
         rd_addr_p1 <= rd_addr;
         wr_en      <= (state_nxt == S_WRITE);
         wr_addr    <= (state_nxt == S_WRITE) ? cnt_nxt : '0;
         wr_data    <= (state_nxt == S_WRITE) ? post_proc(wr_sel) : '0;
      end
   end

   assign bus.oReady                = (state == S_IDLE);
   assign bus.oAddrForDataWeightRam = rd_addr;
   assign bus.oWrEnForResultRam     = wr_en;
   assign bus.oAddrForResultRam     = wr_addr;
   assign bus.oDataToResultRam      = wr_data;
endmodule

// File: tb/tb_systolic_cube_mc.sv
// Directed bench for systolic_cube_mc at the default 3x3x3 configuration.
module tb_systolic_cube_mc;
   localparam int AW = 11;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [31:0] dmem [16];
   logic [31:0] wmem [16];
   logic [31:0] exp_r [9];

   systolic_cube_mc_if #(.AW(AW)) bus ();

   systolic_cube_mc #(
      .ARRAY_NUM(3), .BLOCK_NUM(3), .CUBE_NUM(3), .RAM_DEPTH(2048)
   ) dut (
      .iClk(clk),
      .iRst(rst_n),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // synchronous RAM models: word valid one cycle after its address
   always @(posedge clk) begin
      bus.iDataFromDataRam     <= dmem[bus.oAddrForDataWeightRam[3:0]];
      bus.iWeightFromWeightRam <= wmem[bus.oAddrForDataWeightRam[3:0]];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, got, want);
      end
   endtask

   // Called at #1 after an edge; start is sampled at the next edge (edge 0).
   task automatic run_check(input string name, input bit busy_pulses);
      bus.iStart = 1'b1;
      @(posedge clk); #1;
      bus.iStart = 1'b0;
      for (int e = 0; e < 23; e++) begin
         chk($sformatf("%s.ready%0d", name, e), 32'(bus.oReady), 32'(e == 22));
         chk($sformatf("%s.raddr%0d", name, e), 32'(bus.oAddrForDataWeightRam),
             (e <= 8) ? 32'(e) : 32'd0);
         chk($sformatf("%s.wen%0d", name, e), 32'(bus.oWrEnForResultRam),
             32'(e >= 13 && e <= 21));
         if (e >= 13 && e <= 21) begin
            chk($sformatf("%s.waddr%0d", name, e), 32'(bus.oAddrForResultRam), 32'(e - 13));
            chk($sformatf("%s.wdata%0d", name, e), bus.oDataToResultRam, exp_r[e - 13]);
         end else begin
            chk($sformatf("%s.waddr%0d", name, e), 32'(bus.oAddrForResultRam), 32'd0);
            chk($sformatf("%s.wdata%0d", name, e), bus.oDataToResultRam, 32'd0);
         end
         if (e < 22) begin
            bus.iStart = busy_pulses && (e == 4 || e == 14);
            @(posedge clk); #1;
            bus.iStart = 1'b0;
         end
      end
   endtask

   task automatic load_identity();
      for (int a = 0; a < 16; a++) begin
         dmem[a] = 32'(a + 1);
         wmem[a] = (a == 0 || a == 4 || a == 8) ? 32'd1 : 32'd0;
      end
      for (int n = 0; n < 9; n++) exp_r[n] = 32'(n + 1);
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.iStart = 1'b0;
      bus.iDataFromDataRam     = '0;
      bus.iWeightFromWeightRam = '0;
      for (int a = 0; a < 16; a++) begin dmem[a] = '0; wmem[a] = '0; end
      repeat (2) @(posedge clk);
      #1;
      chk("rst.ready", 32'(bus.oReady), 32'd1);
      chk("rst.raddr", 32'(bus.oAddrForDataWeightRam), 32'd0);
      chk("rst.wen",   32'(bus.oWrEnForResultRam), 32'd0);
      chk("rst.waddr", 32'(bus.oAddrForResultRam), 32'd0);
      chk("rst.wdata", bus.oDataToResultRam, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      load_identity();
      run_check("ident", 1'b0);
      run_check("b2b", 1'b1);

      @(posedge clk); #1;
      for (int a = 0; a < 16; a++) begin dmem[a] = 32'(a + 1); wmem[a] = 32'd1; end
      exp_r = '{32'd6, 32'd6, 32'd6, 32'd15, 32'd15, 32'd15, 32'd24, 32'd24, 32'd24};
      run_check("ones", 1'b0);

      @(posedge clk); #1;
      for (int a = 0; a < 16; a++) begin dmem[a] = 32'hFFFF_FFFF; wmem[a] = 32'd2; end
`ifdef SYSTOLIC_CUBE_RELU_EN
      for (int n = 0; n < 9; n++) exp_r[n] = 32'd0;
`else
      for (int n = 0; n < 9; n++) exp_r[n] = 32'hFFFF_FFFA;
`endif
      run_check("neg", 1'b0);

      @(posedge clk); #1;
      for (int a = 0; a < 16; a++) begin dmem[a] = 32'h7FFF_FFFF; wmem[a] = 32'd2; end
      run_check("wrap", 1'b0);

      // abort in cycle 4 of LOAD
      @(posedge clk); #1;
      load_identity();
      bus.iStart = 1'b1;
      @(posedge clk); #1;
      bus.iStart = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort.pre_ready", 32'(bus.oReady), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("abort.ready", 32'(bus.oReady), 32'd1);
      chk("abort.raddr", 32'(bus.oAddrForDataWeightRam), 32'd0);
      chk("abort.wen",   32'(bus.oWrEnForResultRam), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("abort.hold_wen%0d", c), 32'(bus.oWrEnForResultRam), 32'd0);
         chk($sformatf("abort.hold_raddr%0d", c), 32'(bus.oAddrForDataWeightRam), 32'd0);
      end
      @(negedge clk) rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk($sformatf("abort.idle_wen%0d", c), 32'(bus.oWrEnForResultRam), 32'd0);
         chk($sformatf("abort.idle_ready%0d", c), 32'(bus.oReady), 32'd1);
      end
      run_check("after_rst", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/systolic_cube_mc.md
Name:
systolic_cube_mc

Overview:
- Matrix-multiply engine with a built-in memory controller.
- On start, it reads a data matrix D (ARRAY_NUM x CUBE_NUM) and a weight matrix W (CUBE_NUM x BLOCK_NUM) from two external synchronous RAMs through one shared read address.
- It computes R = D x W on an ARRAY_NUM x BLOCK_NUM grid of MAC PEs, each accumulating over CUBE_NUM steps.
- It writes R into a result RAM.
- Sits between the data/weight/result RAM models and the top-level control that pulses start and waits on ready.

Parameters:
- ARRAY_NUM, 3, rows of D and R (PE grid rows).
- BLOCK_NUM, 3, columns of W and R (PE grid columns).
- CUBE_NUM, 3, inner (accumulation) dimension; default 3 is the validated configuration.
- RAM_DEPTH, 2048, RAM word depth; address width AW = $clog2(RAM_DEPTH). Requires ARRAY_NUM*CUBE_NUM, CUBE_NUM*BLOCK_NUM and ARRAY_NUM*BLOCK_NUM all <= RAM_DEPTH.

Ports:
- iClk  in  1  clock, all logic on rising edge.
- iRst  in  1  reset, asynchronous, active-low.
- iStart  in  1  start request, sampled only in IDLE.
- oReady  out  1  high while IDLE.
- oAddrForDataWeightRam  out  AW  shared read address to data and weight RAMs.
- iDataFromDataRam  in  32  data RAM read word, valid one cycle after its address.
- iWeightFromWeightRam  in  32  weight RAM read word, same timing.
- oWrEnForResultRam  out  1  result RAM write enable.
- oAddrForResultRam  out  AW  result write address.
- oDataToResultRam  out  32  result write data.

Behaviour:
- All words are 32-bit two's complement. Products and accumulation wrap modulo 2^32, with no saturation.
- Memory layout, row-major:
  - D[i][k] at data address i*CUBE_NUM+k.
  - W[k][j] at weight address k*BLOCK_NUM+j.
  - R[i][j] at result address i*BLOCK_NUM+j.
- Reset values: oReady=1, all address outputs 0, oWrEnForResultRam=0, oDataToResultRam=0, accumulators 0, state IDLE.
- Define L = max(ARRAY_NUM*CUBE_NUM, CUBE_NUM*BLOCK_NUM).
- FSM, counted in cycles after the edge at which iStart is sampled:
  - IDLE: oReady=1. iStart=1 at an edge clears the accumulators and enters LOAD, with oReady=0 from that edge.
  - LOAD (L cycles): address counts 0..L-1, one per cycle. Each returned word is captured one cycle later into the D or W register file. Words beyond the size of a matrix are discarded.
  - WAIT (1 cycle): captures the last read word; address returns to 0.
  - COMPUTE (CUBE_NUM cycles): at step k, every PE(i,j) does acc += D[i][k]*W[k][j] in parallel.
  - WRITE (ARRAY_NUM*BLOCK_NUM cycles): oWrEnForResultRam=1, address n = 0..ARRAY_NUM*BLOCK_NUM-1, data = R[n/BLOCK_NUM][n%BLOCK_NUM], one registered write per cycle.
  - Then IDLE: oWrEn drops to 0 and oReady rises.
- Total time from the start edge to oReady=1 is L+1+CUBE_NUM+ARRAY_NUM*BLOCK_NUM+1. At defaults this is 23 cycles: LOAD 1-9, WAIT 10, COMPUTE 11-13, WRITE 14-22, ready at 23.
- Outside LOAD, oAddrForDataWeightRam is held at 0.
- Outside WRITE, oWrEnForResultRam=0 and the result address and data hold 0.
- iStart while busy is ignored, with no queuing.
- A start in the first IDLE cycle after a run is accepted immediately (back-to-back operation).
- Reset asserted mid-run aborts at once: outputs take their reset values and no further writes occur.

Optional Feature:
- Macro SYSTOLIC_CUBE_RELU_EN.
- Defined: each result is passed through ReLU at write time, so negative values (bit31=1) are written as 0. Timing is unchanged.
- Undefined: raw wrapped sums are written.

Test Plan:
- Identity weights: D word at address a = a+1 (a=0..8); W=1 at addresses 0,4,8, else 0; pulse start. Result addresses 0..8 receive 1..9 in cycles 14..22; oReady is low in cycles 1..22 and high at 23.
- All-ones weights: same D, W=1 everywhere. Writes are 6,6,6,15,15,15,24,24,24.
- Negative values: D=-1 everywhere, W=2 everywhere.
  - Without SYSTOLIC_CUBE_RELU_EN, all nine writes are 0xFFFFFFFA.
  - With it, all nine writes are 0.
- Back-to-back: second start pulsed at the first oReady rising edge. The second run repeats identical addresses, data and cycle timing; start pulses during busy cycles 5 and 15 cause no effect.
- Reset mid-LOAD: iRst low at cycle 4. oReady goes to 1 and address goes to 0 immediately, with no writes. After release, a new start produces correct full results.
- Wrap-around: D=0x7FFFFFFF, W=2 everywhere. Each result is 3*0xFFFFFFFE mod 2^32 = 0xFFFFFFFA.
